// File: rtl/sound_dac_pkg.sv
// Shared types and arithmetic helpers for the sound DAC sample-rate controller.
package sound_dac_pkg;

   typedef enum logic [1:0] {
      ST_RAMP_UP = 2'd0,
      ST_RUN     = 2'd1,
      ST_RAMP_DN = 2'd2,
      ST_MUTED   = 2'd3
   } state_e;

   function automatic int unsigned mid(input int unsigned msbi);
      return 32'd1 << msbi;
   endfunction

   // Inputs are at most MSBI+1 bits wide, so the 32-bit sum never overflows.
   function automatic int unsigned mix(input int unsigned a, input int unsigned b);
      return (a + b) >> 1;
   endfunction

endpackage

// File: rtl/dac_tick_gen.sv
// Free-running sample divider; flags the last cycle of every SAMPLE_DIV-cycle period.
module dac_tick_gen #(
   parameter int SAMPLE_DIV = 250
) (
   input  logic clk_i,
   input  logic reset,
   output logic tick
);

   localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      if (cnt_q == LAST) begin
         cnt_d = CW'(0);
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset) begin
         cnt_q <= CW'(0);
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/sound_dac_ctrl.sv
// Sample-rate controller: two-channel sample capture, mixing, and click-free
// ramp/mute sequencing of the delta-sigma DAC input word.
module sound_dac_ctrl
   import sound_dac_pkg::*;
#(
   parameter int MSBI       = 9,
   parameter int SAMPLE_DIV = 250,
   parameter int RAMP_STEP  = 1
) (
   input  logic            clk_i,
   input  logic            reset,
   input  logic [MSBI:0]   ch0_data,
   input  logic            ch0_valid,
   output logic            ch0_ready,
   input  logic [MSBI:0]   ch1_data,
   input  logic            ch1_valid,
   output logic            ch1_ready,
   input  logic            mute_i,
   output logic [MSBI:0]   dac_o,
   output logic            tick_o,
   output logic [1:0]      state_o
);

   localparam int W = MSBI + 1;
   localparam logic [W-1:0] MID_W  = W'(mid(MSBI));
   localparam logic [W-1:0] STEP_W = W'(RAMP_STEP);

   logic           tick_s;
   logic           accept0_s, accept1_s;
   logic [W-1:0]   hold0_q, hold0_d, hold1_q, hold1_d;
   logic           full0_q, full0_d, full1_q, full1_d;
   logic [W-1:0]   dac_q, dac_d;
   logic           tick_q;
   state_e         state_q, state_d;
   logic [W-1:0]   mix_s, up_val_s, dn_val_s;
   logic [W:0]     up_sum_s;

   dac_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
      .clk_i (clk_i),
      .reset (reset),
      .tick  (tick_s)
   );

   assign accept0_s = ch0_valid && !full0_q;
   assign accept1_s = ch1_valid && !full1_q;

   // An accept in the tick cycle keeps the channel full; the tick only clears idle holds.
   always_comb begin
      hold0_d = accept0_s ? ch0_data : hold0_q;
      hold1_d = accept1_s ? ch1_data : hold1_q;
      if (accept0_s) begin
         full0_d = 1'b1;
      end else if (tick_s) begin
         full0_d = 1'b0;
      end else begin
         full0_d = full0_q;
      end
      if (accept1_s) begin
         full1_d = 1'b1;
      end else if (tick_s) begin
         full1_d = 1'b0;
      end else begin
         full1_d = full1_q;
      end
   end

   always_comb begin
      mix_s    = W'(mix(32'(hold0_q), 32'(hold1_q)));
      up_sum_s = {1'b0, dac_q} + {1'b0, STEP_W};
      up_val_s = (up_sum_s >= {1'b0, MID_W}) ? MID_W : up_sum_s[W-1:0];
      if (dac_q > MID_W) begin
         dn_val_s = ((dac_q - MID_W) <= STEP_W) ? MID_W : (dac_q - STEP_W);
      end else begin
         dn_val_s = ((MID_W - dac_q) <= STEP_W) ? MID_W : (dac_q + STEP_W);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset) begin
         state_q <= ST_RAMP_UP;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (tick_s) begin
         case (state_q)
            ST_RAMP_UP: if (up_val_s == MID_W) state_d = mute_i ? ST_MUTED : ST_RUN;
            ST_RUN:     if (mute_i) state_d = ST_RAMP_DN;
            ST_RAMP_DN: if (dn_val_s == MID_W) state_d = ST_MUTED;
            ST_MUTED:   if (!mute_i) state_d = ST_RUN;
            default:    state_d = ST_RAMP_UP;
         endcase
      end
   end

   always_comb begin
      dac_d = dac_q;
      if (tick_s) begin
         case (state_q)
            ST_RAMP_UP: dac_d = up_val_s;
            ST_RUN:     dac_d = mix_s;
            ST_RAMP_DN: dac_d = dn_val_s;
            ST_MUTED:   dac_d = MID_W;
            default:    dac_d = MID_W;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset) begin
         hold0_q <= MID_W;
         hold1_q <= MID_W;
         full0_q <= 1'b0;
         full1_q <= 1'b0;
         dac_q   <= W'(0);
         tick_q  <= 1'b0;
      end else begin
         hold0_q <= hold0_d;
         hold1_q <= hold1_d;
         full0_q <= full0_d;
         full1_q <= full1_d;
         dac_q   <= dac_d;
         tick_q  <= tick_s;
      end
   end

   assign ch0_ready = !full0_q;
   assign ch1_ready = !full1_q;
   assign dac_o     = dac_q;
   assign tick_o    = tick_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_sound_dac_ctrl.sv
// Directed bench for sound_dac_ctrl with MSBI=9, SAMPLE_DIV=4, RAMP_STEP=128.
module tb_sound_dac_ctrl;

   logic       clk_i = 1'b0;
   logic       reset;
   logic [9:0] ch0_data, ch1_data;
   logic       ch0_valid, ch1_valid, ch0_ready, ch1_ready;
   logic       mute_i;
   logic [9:0] dac_o;
   logic       tick_o;
   logic [1:0] state_o;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int ch0;
      int ch1;
      int exp_dac;
   } vec_t;
   vec_t vecs[5];

   sound_dac_ctrl #(.MSBI(9), .SAMPLE_DIV(4), .RAMP_STEP(128)) dut (
      .clk_i     (clk_i),
      .reset     (reset),
      .ch0_data  (ch0_data),
      .ch0_valid (ch0_valid),
      .ch0_ready (ch0_ready),
      .ch1_data  (ch1_data),
      .ch1_valid (ch1_valid),
      .ch1_ready (ch1_ready),
      .mute_i    (mute_i),
      .dac_o     (dac_o),
      .tick_o    (tick_o),
      .state_o   (state_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Advance until tick_o is seen high (dac_o just updated); n = cycles waited.
   task automatic wait_tick(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!tick_o && n < 50);
      if (!tick_o) begin
         failures++;
         $display("FAIL tick_timeout: no tick within %0d cycles", n);
      end
   endtask

   task automatic tick_expect(input string name, input int exp_dac, input int exp_state);
      int n;
      wait_tick(n);
      chk({name, "_dac"}, int'(dac_o), exp_dac);
      chk({name, "_state"}, int'(state_o), exp_state);
   endtask

   initial begin
      int n;
      vecs[0] = '{ch0: 700,  ch1: 300,  exp_dac: 500};
      vecs[1] = '{ch0: 1023, ch1: 1023, exp_dac: 1023};
      vecs[2] = '{ch0: 0,    ch1: 1,    exp_dac: 0};
      vecs[3] = '{ch0: 511,  ch1: 512,  exp_dac: 511};
      vecs[4] = '{ch0: 100,  ch1: 512,  exp_dac: 306};

      reset = 1'b1; ch0_data = 10'd0; ch1_data = 10'd0;
      ch0_valid = 1'b0; ch1_valid = 1'b0; mute_i = 1'b0;
      step(); step();
      reset = 1'b0;
      chk("rst_dac", int'(dac_o), 0);
      chk("rst_tick", int'(tick_o), 0);
      chk("rst_state", int'(state_o), 0);
      chk("rst_ready0", int'(ch0_ready), 1);
      chk("rst_ready1", int'(ch1_ready), 1);

      // Start-up ramp
      wait_tick(n);
      chk("first_tick_cycles", n, 4);
      chk("ramp1", int'(dac_o), 128);
      for (int i = 2; i <= 4; i++) begin
         wait_tick(n);
         chk("tick_period", n, 4);
         chk("ramp_dac", int'(dac_o), 128 * i);
         chk("ramp_state", int'(state_o), (i == 4) ? 1 : 0);
      end
      tick_expect("run_idle", 512, 1);

      // Mixing vectors: load both channels right after a tick, check at the next
      for (int i = 0; i < 5; i++) begin
         ch0_data = 10'(vecs[i].ch0); ch1_data = 10'(vecs[i].ch1);
         ch0_valid = 1'b1; ch1_valid = 1'b1;
         step();
         ch0_valid = 1'b0; ch1_valid = 1'b0;
         chk("vec_ready_low", int'(ch0_ready), 0);
         tick_expect("vec", vecs[i].exp_dac, 1);
      end

      // Backpressure: valid held across two values, hold1 stays 512
      ch0_data = 10'd100; ch0_valid = 1'b1;
      step();
      chk("bp_ready_drop", int'(ch0_ready), 0);
      ch0_data = 10'd900;
      wait_tick(n);
      chk("bp_first", int'(dac_o), 306);
      chk("bp_ready_after_tick", int'(ch0_ready), 1);
      step();
      ch0_valid = 1'b0;
      chk("bp_ready_second", int'(ch0_ready), 0);
      tick_expect("bp_second", 706, 1);

      // Accept on the tick cycle: tick uses old hold (900)
      step(); step(); step();
      chk("tc_ready_in_tick", int'(ch0_ready), 1);
      ch0_data = 10'd200; ch0_valid = 1'b1;
      step();
      ch0_valid = 1'b0;
      chk("tc_tick", int'(tick_o), 1);
      chk("tc_old_value", int'(dac_o), 706);
      chk("tc_ready_low", int'(ch0_ready), 0);
      step(); step(); step();
      chk("tc_ready_still_low", int'(ch0_ready), 0);
      step();
      chk("tc_tick2", int'(tick_o), 1);
      chk("tc_new_value", int'(dac_o), 356);
      chk("tc_ready_back", int'(ch0_ready), 1);

      // Mute ramp-down from 1000
      ch0_data = 10'd1000; ch1_data = 10'd1000;
      ch0_valid = 1'b1; ch1_valid = 1'b1;
      step();
      ch0_valid = 1'b0; ch1_valid = 1'b0;
      tick_expect("pre_mute", 1000, 1);
      mute_i = 1'b1;
      tick_expect("mute_run_tick", 1000, 2);
      tick_expect("dn1", 872, 2);
      tick_expect("dn2", 744, 2);
      mute_i = 1'b0;
      tick_expect("dn3_ignore_unmute", 616, 2);
      mute_i = 1'b1;
      tick_expect("dn4", 512, 3);
      tick_expect("muted_hold", 512, 3);
      mute_i = 1'b0;
      tick_expect("unmute_tick", 512, 1);
      tick_expect("unmute_mix", 1000, 1);

      // Reset mid ramp-down with a pending sample
      mute_i = 1'b1;
      tick_expect("mute2_run", 1000, 2);
      tick_expect("mute2_dn", 872, 2);
      ch0_data = 10'd50; ch0_valid = 1'b1;
      step();
      ch0_valid = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0; mute_i = 1'b0;
      chk("mrst_dac", int'(dac_o), 0);
      chk("mrst_state", int'(state_o), 0);
      chk("mrst_tick", int'(tick_o), 0);
      chk("mrst_ready0", int'(ch0_ready), 1);
      chk("mrst_ready1", int'(ch1_ready), 1);
      wait_tick(n);
      chk("mrst_first_tick_cycles", n, 4);
      chk("mrst_ramp1", int'(dac_o), 128);
      tick_expect("mrst_ramp2", 256, 0);
      tick_expect("mrst_ramp3", 384, 0);
      tick_expect("mrst_ramp4", 512, 1);
      tick_expect("mrst_hold_mid", 512, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
